i2s_receiver: RTL and testbench
===============================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter: SAMPLE_W, 24, bits captured per channel word (MSB-first).
REQ-002 SHALL have parameter: SYNC_STAGES, 2, flip-flop stages on each asynchronous pin input.
REQ-003 SHALL have port: clk  input  1  system clock (MAX10_CLK1_50, 50 MHz); one clock, all logic on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: LRCLK  input  1  codec word-select, asynchronous to clk; 0 = left, 1 = right.
REQ-006 SHALL have port: SCLK  input  1  codec bit clock, asynchronous to clk, at most clk/8.
REQ-007 SHALL have port: SDIN  input  1  codec serial data (codec DOUT), valid on SCLK rising edge.
REQ-008 SHALL have port: left_sample  output  SAMPLE_W  last complete left word, two's complement.
REQ-009 SHALL have port: right_sample  output  SAMPLE_W  last complete right word, two's complement.
REQ-010 SHALL have port: sample_valid  output  1  a left/right pair is held for the consumer.
REQ-011 SHALL have port: sample_ready  input  1  consumer accepts the pair when high with sample_valid.
REQ-012 SHALL have port: overrun  output  1  sticky; a pair was overwritten before it was accepted.
REQ-013 SHALL have port: frame_error  output  1  sticky; a channel word ended before SAMPLE_W bits arrived.

Function
REQ-014 SHALL pass LRCLK, SCLK and SDIN through SYNC_STAGES flip-flops, then detect a SCLK rising edge as a 1-cycle strobe; pin edge to strobe is SYNC_STAGES+1 clk cycles.
REQ-015 SHALL, on each strobe, sample the synchronised LRCLK and SDIN together; no logic acts between strobes except the handshake.
REQ-016 SHALL treat a strobe whose LRCLK differs from the previous strobe's LRCLK as the I2S delay slot: SDIN ignored, bit counter cleared, channel = new LRCLK.
REQ-017 SHALL shift SDIN into the channel shift register MSB-first on the next SAMPLE_W strobes, then ignore further bits until the next LRCLK change.
REQ-018 SHALL use FSM states IDLE -> WAIT_LEFT -> SHIFT -> PAD, with PAD -> SHIFT on an LRCLK change.
REQ-019 SHALL leave WAIT_LEFT only on an LRCLK 1->0 delay slot, so capture always starts with a left word.
REQ-020 SHALL, on the strobe that completes the SAMPLE_W-th left bit, latch the word into an internal left holding register.
REQ-021 SHALL, on the strobe that completes the SAMPLE_W-th right bit, load left_sample and right_sample on the next clk edge and set sample_valid that same edge.
REQ-022 SHALL hold sample_valid high until a clk edge with sample_ready=1, then clear it, unless REQ-024 applies.
REQ-023 SHALL, if a pair completes while sample_valid=1 and sample_ready=0, overwrite both outputs, keep sample_valid=1 and set overrun.
REQ-024 SHALL, if a pair completes in the same cycle sample_ready=1 is accepted, load the new pair, keep sample_valid=1 and leave overrun unchanged.
REQ-025 SHALL, on an LRCLK change with fewer than SAMPLE_W bits shifted, set frame_error, discard the partial word and any held left word, and go to WAIT_LEFT.
REQ-026 SHALL treat SCLK words longer than SAMPLE_W bits (e.g. 32-bit slots) as normal, with the excess bits dropped in PAD.

Reset
REQ-027 SHALL, while reset=1 at a clk edge, clear left_sample, right_sample, sample_valid, overrun and frame_error, the bit counter, the shift and holding registers and all synchroniser stages, with the FSM to IDLE.
REQ-028 SHALL move from IDLE to WAIT_LEFT on the first clk after reset deasserts.
REQ-029 SHALL abandon any partial frame when reset is asserted mid-word; the first pair after reset is the first complete left+right pair.

Structure
REQ-030 SHALL take SAMPLE_W default and the FSM state enum from the shared audio package, the same package used by the I2S transmitter and mixer.
REQ-031 SHALL implement the synchroniser plus SCLK edge detector as one sub-module, sync_edge_detect, instantiated for SCLK, with plain sync for LRCLK and SDIN.

Verification
REQ-032 SHALL cover: 48 kHz frames of 32 SCLK per channel, left=24'h123456, right=24'hABCDEF -> sample_valid rises with outputs exactly those values, frame_error=0.
REQ-033 SHALL cover: sample_ready held 0 across two frames -> second pair replaces the first, sample_valid stays 1, overrun=1.
REQ-034 SHALL cover: sample_ready pulsed on the exact cycle a new pair completes -> new pair visible, sample_valid=1, overrun=0.
REQ-035 SHALL cover: left word cut to 16 SCLK by an early LRCLK edge -> frame_error=1, no pair output until the next full left+right frame.
REQ-036 SHALL cover: capture started mid right-channel -> first output is the following left/right pair only.
REQ-037 SHALL cover: reset asserted after 10 bits of a left word -> all outputs 0, and the next complete frame decodes correctly.

Source files
------------

// File: rtl/i2s_receiver_pkg.sv
// rtl/i2s_receiver_pkg.sv - shared audio types: default word width and receiver FSM states
package i2s_receiver_pkg;

  localparam int SAMPLE_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LEFT,
    ST_SHIFT,
    ST_PAD
  } i2s_rx_state_e;

endpackage

// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - left/right sample pair handed to the consumer with valid/ready
interface i2s_receiver_if
  import i2s_receiver_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
);
  logic [SAMPLE_W-1:0] left_sample;
  logic [SAMPLE_W-1:0] right_sample;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output left_sample,
    output right_sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  left_sample,
    input  right_sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_receiver_sync_edge_detect.sv
// rtl/i2s_receiver_sync_edge_detect.sv - pin synchroniser with registered rising-edge strobe
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // The strobe is registered so pin edge to strobe is STAGES+1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
    end
  end
endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S receiver: captures left/right words and offers them as a valid/ready pair
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           LRCLK,
  input  logic           SCLK,
  input  logic           SDIN,
  i2s_receiver_if.master smp,
  output logic           overrun,
  output logic           frame_error
);
  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  i2s_rx_state_e          state_q, state_d;
  logic [SYNC_STAGES-1:0] lr_sync, sd_sync;
  logic                   strobe, lr_now, sd_now, prev_lr, lr_change, chan_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SAMPLE_W-1:0]    shift_q, shift_next, left_hold, left_q, right_q;
  logic                   valid_q, slot_start, shift_en, word_err, word_done, pair_done;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_edge (
    .clk  (clk),
    .reset(reset),
    .din  (SCLK),
    .rise (strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      lr_sync <= '0;
      sd_sync <= '0;
    end else begin
      lr_sync <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
      sd_sync <= {sd_sync[SYNC_STAGES-2:0], SDIN};
    end
  end

  assign lr_now     = lr_sync[SYNC_STAGES-1];
  assign sd_now     = sd_sync[SYNC_STAGES-1];
  assign lr_change  = lr_now != prev_lr;
  assign shift_next = {shift_q[SAMPLE_W-2:0], sd_now};
  assign word_done  = shift_en && (bit_cnt == CNT_W'(SAMPLE_W - 1));
  assign pair_done  = word_done && chan_q;

  always_comb begin
    state_d    = state_q;
    slot_start = 1'b0;
    shift_en   = 1'b0;
    word_err   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_WAIT_LEFT;
      // Only a right-to-left delay slot may start capture, so pairs stay aligned.
      ST_WAIT_LEFT: begin
        if (strobe && lr_change && !lr_now) begin
          slot_start = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (strobe) begin
          if (lr_change) begin
            word_err = 1'b1;
            state_d  = ST_WAIT_LEFT;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == CNT_W'(SAMPLE_W - 1)) state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (strobe && lr_change) begin
          slot_start = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prev_lr     <= 1'b0;
      chan_q      <= 1'b0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      left_hold   <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q <= state_d;
      if (strobe) prev_lr <= lr_now;
      if (slot_start) begin
        chan_q  <= lr_now;
        bit_cnt <= '0;
        shift_q <= '0;
      end
      if (shift_en) begin
        shift_q <= shift_next;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (word_err) begin
        frame_error <= 1'b1;
        shift_q     <= '0;
        bit_cnt     <= '0;
        left_hold   <= '0;
      end
      if (word_done && !chan_q) left_hold <= shift_next;
      // A completing pair always wins over acceptance; overrun only if the old pair was never taken.
      if (pair_done) begin
        left_q  <= left_hold;
        right_q <= shift_next;
        valid_q <= 1'b1;
        if (valid_q && !smp.sample_ready) overrun <= 1'b1;
      end else if (valid_q && smp.sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign smp.left_sample  = left_q;
  assign smp.right_sample = right_q;
  assign smp.sample_valid = valid_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - randomized I2S frames checked against a slot-level reference model
module tb_i2s_receiver;
  localparam int W = 24;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic LRCLK = 1'b0;
  logic SCLK = 1'b0;
  logic SDIN = 1'b0;
  logic overrun, frame_error;

  i2s_receiver_if #(.SAMPLE_W(W)) smp ();

  i2s_receiver #(.SAMPLE_W(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .LRCLK      (LRCLK),
    .SCLK       (SCLK),
    .SDIN       (SDIN),
    .smp        (smp.master),
    .overrun    (overrun),
    .frame_error(frame_error)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic         lr;
    int           len;
    logic [W-1:0] word;
  } slot_t;

  slot_t        slots[$];
  logic [W-1:0] exp_l[$], exp_r[$], got_l[$], got_r[$];
  logic         exp_ferr;
  int           errors = 0;
  int           checks = 0;
  bit           mon_en = 0;

  always @(negedge clk) begin
    if (mon_en && smp.sample_valid) begin
      got_l.push_back(smp.left_sample);
      got_r.push_back(smp.right_sample);
    end
  end

  // Reference: walk the slot list; a slot counts only once armed by a right->left change,
  // a slot with fewer than W data bits followed by a channel change is a framing error.
  task automatic model_run();
    logic prev, armed, blocked, have_left;
    logic [W-1:0] hold;
    prev = 0; armed = 0; blocked = 0; have_left = 0; hold = '0;
    exp_l.delete(); exp_r.delete(); exp_ferr = 0;
    for (int i = 0; i < slots.size(); i++) begin
      if (!armed && !blocked && slots[i].lr != prev && slots[i].lr == 1'b0) armed = 1;
      blocked = 0;
      if (armed) begin
        if (slots[i].len - 1 < W) begin
          if (i + 1 < slots.size() && slots[i+1].lr != slots[i].lr) begin
            exp_ferr = 1; armed = 0; have_left = 0; blocked = 1;
          end
        end else if (slots[i].lr == 1'b0) begin
          hold = slots[i].word; have_left = 1;
        end else if (have_left) begin
          exp_l.push_back(hold); exp_r.push_back(slots[i].word);
        end
      end
      prev = slots[i].lr;
    end
  endtask

  task automatic do_reset();
    reset = 1; LRCLK = 0; SCLK = 0; SDIN = 0;
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    got_l.delete(); got_r.delete();
  endtask

  task automatic drive_bit(input logic lr, input logic b, input bit pulse);
    SCLK = 0; LRCLK = lr; SDIN = b;
    repeat (4) @(negedge clk);
    SCLK = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (pulse && k == 3) smp.sample_ready = 1;
      if (pulse && k == 4) smp.sample_ready = 0;
    end
  endtask

  task automatic drive_slot(input slot_t s, input int pulse_bit);
    logic v;
    for (int b = 0; b < s.len; b++) begin
      v = (b >= 1 && b <= W) ? s.word[W-b] : 1'($urandom);
      drive_bit(s.lr, v, b == pulse_bit);
    end
  endtask

  task automatic drive_all();
    foreach (slots[i]) drive_slot(slots[i], -1);
    SCLK = 0;
    repeat (12) @(negedge clk);
  endtask

  function automatic slot_t mk(input logic lr, input int len, input logic [W-1:0] word);
    slot_t s;
    s.lr = lr; s.len = len; s.word = word;
    return s;
  endfunction

  task automatic test_reset();
    reset = 1; LRCLK = 1; SCLK = 0; SDIN = 1;
    repeat (5) @(negedge clk);
    checks += 5;
    if (smp.left_sample !== '0) begin errors++; $display("FAIL reset_left got=%h exp=0", smp.left_sample); end
    if (smp.right_sample !== '0) begin errors++; $display("FAIL reset_right got=%h exp=0", smp.right_sample); end
    if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", smp.sample_valid); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_error); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    smp.sample_ready = 1; mon_en = 1;
    slots.delete();
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 32, 24'h123456));
    slots.push_back(mk(1, 32, 24'hABCDEF));
    drive_all();
    mon_en = 0;
    checks += 4;
    if (got_l.size() !== 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", got_l.size()); end
    else begin
      if (got_l[0] !== 24'h123456) begin errors++; $display("FAIL basic_left got=%h exp=123456", got_l[0]); end
      if (got_r[0] !== 24'hABCDEF) begin errors++; $display("FAIL basic_right got=%h exp=abcdef", got_r[0]); end
    end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL basic_ferr got=%b exp=0", frame_error); end
  endtask

  task automatic test_random_frames(input bit start_mid_right, input string tag);
    do_reset();
    smp.sample_ready = 1; mon_en = 1;
    slots.delete();
    slots.push_back(mk(1, start_mid_right ? 12 : 32, $urandom));
    for (int f = 0; f < 4; f++) begin
      slots.push_back(mk(0, $urandom_range(32, 25), $urandom));
      slots.push_back(mk(1, $urandom_range(32, 25), $urandom));
    end
    model_run();
    drive_all();
    mon_en = 0;
    checks += 2;
    if (got_l.size() !== exp_l.size()) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_l.size(), exp_l.size()); end
    if (frame_error !== exp_ferr) begin errors++; $display("FAIL %s_ferr got=%b exp=%b", tag, frame_error, exp_ferr); end
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
      checks++;
      if (got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
        errors++;
        $display("FAIL %s_pair%0d got=%h/%h exp=%h/%h", tag, i, got_l[i], got_r[i], exp_l[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] w3, w4;
    do_reset();
    smp.sample_ready = 0;
    w3 = $urandom; w4 = $urandom;
    slots.delete();
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 32, $urandom));
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 32, w3));
    slots.push_back(mk(1, 32, w4));
    drive_all();
    checks += 4;
    if (smp.sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", smp.sample_valid); end
    if (smp.left_sample !== w3) begin errors++; $display("FAIL ovr_left got=%h exp=%h", smp.left_sample, w3); end
    if (smp.right_sample !== w4) begin errors++; $display("FAIL ovr_right got=%h exp=%h", smp.right_sample, w4); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    smp.sample_ready = 1;
    @(negedge clk);
    smp.sample_ready = 0;
    checks += 2;
    if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%b exp=0", smp.sample_valid); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_ready_same_cycle();
    logic [W-1:0] w3, w4;
    do_reset();
    smp.sample_ready = 0;
    w3 = $urandom; w4 = $urandom;
    slots.delete();
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 32, $urandom));
    slots.push_back(mk(1, 32, $urandom));
    drive_all();
    checks++;
    if (smp.sample_valid !== 1'b1) begin errors++; $display("FAIL same_first_valid got=%b exp=1", smp.sample_valid); end
    drive_slot(mk(0, 32, w3), -1);
    drive_slot(mk(1, 32, w4), W);
    SCLK = 0;
    repeat (12) @(negedge clk);
    checks += 4;
    if (smp.sample_valid !== 1'b1) begin errors++; $display("FAIL same_valid got=%b exp=1", smp.sample_valid); end
    if (smp.left_sample !== w3) begin errors++; $display("FAIL same_left got=%h exp=%h", smp.left_sample, w3); end
    if (smp.right_sample !== w4) begin errors++; $display("FAIL same_right got=%h exp=%h", smp.right_sample, w4); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL same_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_frame_error();
    do_reset();
    smp.sample_ready = 1; mon_en = 1;
    slots.delete();
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 17, $urandom));
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 32, $urandom));
    slots.push_back(mk(1, 32, $urandom));
    model_run();
    drive_all();
    mon_en = 0;
    checks += 3;
    if (frame_error !== 1'b1) begin errors++; $display("FAIL ferr_flag got=%b exp=1", frame_error); end
    if (got_l.size() !== exp_l.size()) begin errors++; $display("FAIL ferr_count got=%0d exp=%0d", got_l.size(), exp_l.size()); end
    else if (exp_l.size() > 0 && (got_l[0] !== exp_l[0] || got_r[0] !== exp_r[0])) begin
      errors++; $display("FAIL ferr_pair got=%h/%h exp=%h/%h", got_l[0], got_r[0], exp_l[0], exp_r[0]);
    end
    if (frame_error !== exp_ferr) begin errors++; $display("FAIL ferr_model got=%b exp=%b", frame_error, exp_ferr); end
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] w5;
    do_reset();
    smp.sample_ready = 1;
    slots.delete();
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 32, 24'hFFFFFF));
    slots.push_back(mk(1, 32, 24'hFFFFFF));
    drive_all();
    w5 = $urandom;
    for (int b = 0; b <= 10; b++) drive_bit(0, (b == 0) ? 1'b0 : w5[W-b], 0);
    reset = 1; SCLK = 0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (smp.left_sample !== '0) begin errors++; $display("FAIL rstmid_left got=%h exp=0", smp.left_sample); end
    if (smp.right_sample !== '0) begin errors++; $display("FAIL rstmid_right got=%h exp=0", smp.right_sample); end
    if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", smp.sample_valid); end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL rstmid_ferr got=%b exp=0", frame_error); end
    reset = 0;
    @(negedge clk);
    got_l.delete(); got_r.delete();
    mon_en = 1;
    slots.delete();
    slots.push_back(mk(0, 21, $urandom));
    slots.push_back(mk(1, 32, $urandom));
    slots.push_back(mk(0, 32, $urandom));
    slots.push_back(mk(1, 32, $urandom));
    model_run();
    drive_all();
    mon_en = 0;
    checks += 2;
    if (got_l.size() !== exp_l.size()) begin errors++; $display("FAIL rstmid_count got=%0d exp=%0d", got_l.size(), exp_l.size()); end
    else if (exp_l.size() > 0 && (got_l[0] !== exp_l[0] || got_r[0] !== exp_r[0])) begin
      errors++; $display("FAIL rstmid_pair got=%h/%h exp=%h/%h", got_l[0], got_r[0], exp_l[0], exp_r[0]);
    end
    if (frame_error !== 1'b0) begin errors++; $display("FAIL rstmid_ferr_after got=%b exp=0", frame_error); end
  endtask

  initial begin
    smp.sample_ready = 0;
    test_reset();
    test_basic_frame();
    test_random_frames(0, "rand");
    test_overrun();
    test_ready_same_cycle();
    test_frame_error();
    test_random_frames(1, "midright");
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
